// File: rtl/ifu_fetch_queue.sv
// ifu_fetch_queue
//   Instruction-fetch front end feeding decode. It issues in-order word fetches to
//   instruction memory and tags each request with its PC. Returned words are buffered
//   with their PCs in a DEPTH-entry FIFO, and the head entry is presented to decode over
//   valid/ready. A redirect flushes the FIFO and restarts fetch at a new PC. Responses
//   still in flight at the redirect are counted and discarded when they return.
//
// Ports
//   clk, rst                         clock; synchronous active-high reset
//   redirect_valid, redirect_pc      flush and restart fetch at redirect_pc (word aligned)
//   imem_req_valid/addr/ready        fetch request channel
//   imem_resp_valid/data             in-order fetch responses (no backpressure)
//   out_valid/pc/inst, out_ready     head-of-queue {pc, inst} to decode
module ifu_fetch_queue #(
    parameter int unsigned     XLEN     = 64,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(64'h8000_0000)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_resp_valid,
    input  logic [31:0]     imem_resp_data,
    output logic            out_valid,
    output logic [XLEN-1:0] out_pc,
    output logic [31:0]     out_inst,
    input  logic            out_ready
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    typedef enum logic [0:0] {StBoot, StFetch} state_e;

    state_e          r_state;
    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] r_q_pc   [DEPTH];
    logic [31:0]     r_q_inst [DEPTH];
    logic [PW-1:0]   r_rd_ptr;
    logic [PW-1:0]   r_wr_ptr;
    logic [CW-1:0]   r_count;
    logic [CW-1:0]   r_inflight;
    logic [CW-1:0]   r_drop_cnt;
    logic [XLEN-1:0] r_tag_pc [DEPTH];
    logic [PW-1:0]   r_tag_rd_ptr;
    logic [PW-1:0]   r_tag_wr_ptr;

    logic          w_req_fire;
    logic          w_resp_fire;
    logic          w_redirect;
    logic          w_push;
    logic          w_drop;
    logic          w_pop;
    logic [CW:0]   w_credit_sum;
    logic [CW-1:0] w_inflight_nxt;
    logic          w_unused_rpc_lo;

    // Low PC bits of the redirect target are ignored.
    assign w_unused_rpc_lo = ^redirect_pc[1:0];

    // Credit: every in-flight request has a FIFO slot reserved, so the FIFO can't overflow.
    assign w_credit_sum   = {1'b0, r_inflight} + {1'b0, r_count};
    assign imem_req_valid = !rst && (r_state == StFetch) && (w_credit_sum < DEPTH_W);
    assign imem_req_addr  = r_fetch_pc;

    assign w_req_fire  = imem_req_valid && imem_req_ready;
    assign w_resp_fire = imem_resp_valid && !rst;
    assign w_redirect  = redirect_valid && !rst && (r_state == StFetch);

    // A response in a redirect cycle is stale by definition and is never written.
    assign w_push = w_resp_fire && !w_redirect && (r_drop_cnt == '0);
    assign w_drop = w_resp_fire && !w_redirect && (r_drop_cnt != '0);

    assign out_valid = !rst && (r_count != '0);
    assign out_pc    = r_q_pc[r_rd_ptr];
    assign out_inst  = r_q_inst[r_rd_ptr];
    assign w_pop     = out_valid && out_ready && !w_redirect;

    always_comb begin
        w_inflight_nxt = r_inflight;
        if (w_req_fire && !w_resp_fire) begin
            w_inflight_nxt = r_inflight + CW'(1);
        end else if (!w_req_fire && w_resp_fire) begin
            w_inflight_nxt = r_inflight - CW'(1);
        end
    end

    // Storage arrays carry no reset; their occupancy is tracked by the control state.
    always_ff @(posedge clk) begin
        if (w_req_fire) begin
            r_tag_pc[r_tag_wr_ptr] <= r_fetch_pc;
        end
        if (w_push) begin
            r_q_pc[r_wr_ptr]   <= r_tag_pc[r_tag_rd_ptr];
            r_q_inst[r_wr_ptr] <= imem_resp_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= StBoot;
            r_fetch_pc   <= RESET_PC;
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_count      <= '0;
            r_inflight   <= '0;
            r_drop_cnt   <= '0;
            r_tag_rd_ptr <= '0;
            r_tag_wr_ptr <= '0;
        end else begin
            if (r_state == StBoot) begin
                r_state <= StFetch;
            end

            // The tag FIFO is never flushed: stale responses still pop their tags.
            if (w_req_fire) begin
                r_tag_wr_ptr <= r_tag_wr_ptr + PW'(1);
            end
            if (w_resp_fire) begin
                r_tag_rd_ptr <= r_tag_rd_ptr + PW'(1);
            end
            r_inflight <= w_inflight_nxt;

            if (w_redirect) begin
                r_fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
                r_rd_ptr   <= '0;
                r_wr_ptr   <= '0;
                r_count    <= '0;
                // Everything still outstanding after this cycle belongs to the old path.
                r_drop_cnt <= w_inflight_nxt;
            end else begin
                if (w_req_fire) begin
                    r_fetch_pc <= r_fetch_pc + XLEN'(4);
                end
                if (w_drop) begin
                    r_drop_cnt <= r_drop_cnt - CW'(1);
                end
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + PW'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PW'(1);
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + CW'(1);
                    2'b01:   r_count <= r_count - CW'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    a_resp_has_request: assert property (@(posedge clk) disable iff (rst)
        imem_resp_valid |-> (r_inflight != '0));

endmodule

// File: tb/tb_ifu_fetch_queue.sv
// Bench for ifu_fetch_queue: a per-cycle vector table (inputs plus expected outputs)
// driven against an in-order memory model, followed by a randomized run with redirects
// that checks the output PC stream and instruction words.
module tb_ifu_fetch_queue;

    localparam logic [63:0] B = 64'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        imem_req_valid;
    logic [63:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        out_valid;
    logic [63:0] out_pc;
    logic [31:0] out_inst;
    logic        out_ready;

    ifu_fetch_queue dut (
        .clk             (clk),
        .rst             (rst),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_req_ready  (imem_req_ready),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .out_valid       (out_valid),
        .out_pc          (out_pc),
        .out_inst        (out_inst),
        .out_ready       (out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          rst;
        bit          ordy;
        bit          redir;
        logic [63:0] rpc;
        int          lat;
        bit          ca;
        bit          erv;
        logic [63:0] eaddr;
        bit          eov;
        logic [63:0] epc;
    } vec_t;

    typedef struct {
        logic [63:0] addr;
        int          due;
    } req_t;

    vec_t vt[$];
    req_t mq[$];
    int   cyc = 0;
    int   last_due = 0;
    int   cur_lat = 1;
    int   n_vec = 0;
    int   n_err = 0;

    function automatic logic [31:0] f_inst(input logic [63:0] a);
        return a[31:0] ^ 32'h5A5A_0000;
    endfunction

    function automatic void row(input int r, input int o, input int d, input logic [63:0] rpc,
                                input int lat, input int ca, input int erv,
                                input logic [63:0] ea, input int eov, input logic [63:0] ep);
        vec_t v;
        v.rst = (r != 0);   v.ordy = (o != 0);  v.redir = (d != 0); v.rpc = rpc;
        v.lat = lat;        v.ca = (ca != 0);   v.erv = (erv != 0); v.eaddr = ea;
        v.eov = (eov != 0); v.epc = ep;
        vt.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    // Memory model: drive this cycle's response from the head of the pending queue.
    task automatic drive_mem();
        if (rst) begin
            mq.delete();
            last_due        = cyc;
            imem_resp_valid = 1'b0;
            imem_resp_data  = '0;
        end else if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = f_inst(mq[0].addr);
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = '0;
        end
    endtask

    // Record handshakes of the current cycle, then move to the next negedge.
    task automatic advance();
        req_t r;
        int   d;
        if (imem_req_valid && imem_req_ready) begin
            d = cyc + cur_lat;
            if (d <= last_due) d = last_due + 1;
            last_due = d;
            r.addr = imem_req_addr;
            r.due  = d;
            mq.push_back(r);
        end
        if (imem_resp_valid) mq.delete(0);
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic rst_rows(input int o, input int lat);
        row(1, o, 0, 0, lat, 0, 0, 0, 0, 0);
        row(1, o, 0, 0, lat, 1, 0, B, 0, 0);
        row(0, o, 0, 0, lat, 1, 0, B, 0, 0);   // BOOT
    endtask

    initial begin
        logic [63:0] exp_pc;
        int          n_pop;

        // 1-cycle memory, decode always ready: sequential stream.
        rst_rows(1, 1);
        row(0, 1, 0, 0, 1, 1, 1, B,          0, 0);
        row(0, 1, 0, 0, 1, 1, 1, B + 64'h4,  0, 0);
        row(0, 1, 0, 0, 1, 1, 1, B + 64'h8,  1, B);
        row(0, 1, 0, 0, 1, 1, 1, B + 64'hC,  1, B + 64'h4);
        row(0, 1, 0, 0, 1, 1, 1, B + 64'h10, 1, B + 64'h8);

        // Decode stalled: fill to DEPTH, stop requesting, then drain and resume.
        rst_rows(0, 1);
        row(0, 0, 0, 0, 1, 1, 1, B,          0, 0);
        row(0, 0, 0, 0, 1, 1, 1, B + 64'h4,  0, 0);
        row(0, 0, 0, 0, 1, 1, 1, B + 64'h8,  1, B);
        row(0, 0, 0, 0, 1, 1, 1, B + 64'hC,  1, B);
        row(0, 0, 0, 0, 1, 1, 0, B + 64'h10, 1, B);
        row(0, 0, 0, 0, 1, 1, 0, B + 64'h10, 1, B);
        row(0, 1, 0, 0, 1, 1, 0, B + 64'h10, 1, B);
        row(0, 1, 0, 0, 1, 1, 1, B + 64'h10, 1, B + 64'h4);
        row(0, 1, 0, 0, 1, 1, 1, B + 64'h14, 1, B + 64'h8);
        row(0, 1, 0, 0, 1, 1, 1, B + 64'h18, 1, B + 64'hC);
        row(0, 1, 0, 0, 1, 1, 1, B + 64'h1C, 1, B + 64'h10);
        row(0, 1, 0, 0, 1, 1, 1, B + 64'h20, 1, B + 64'h14);

        // 3-cycle memory, redirect with 3 outstanding (incl. same-cycle request).
        rst_rows(1, 3);
        row(0, 1, 0, 0,             3, 1, 1, B,           0, 0);
        row(0, 1, 0, 0,             3, 1, 1, B + 64'h4,   0, 0);
        row(0, 1, 1, B + 64'h103,   3, 1, 1, B + 64'h8,   0, 0);
        row(0, 1, 0, 0,             3, 1, 1, B + 64'h100, 0, 0);
        row(0, 1, 0, 0,             3, 1, 1, B + 64'h104, 0, 0);
        row(0, 1, 0, 0,             3, 1, 1, B + 64'h108, 0, 0);
        row(0, 1, 0, 0,             3, 1, 1, B + 64'h10C, 0, 0);
        row(0, 1, 0, 0,             3, 1, 0, B + 64'h110, 1, B + 64'h100);
        row(0, 1, 0, 0,             3, 1, 1, B + 64'h110, 1, B + 64'h104);
        row(0, 1, 0, 0,             3, 1, 1, B + 64'h114, 1, B + 64'h108);
        row(0, 1, 0, 0,             3, 1, 1, B + 64'h118, 1, B + 64'h10C);
        row(0, 1, 0, 0,             3, 1, 1, B + 64'h11C, 0, 0);
        row(0, 1, 0, 0,             3, 1, 0, B + 64'h120, 1, B + 64'h110);

        // Redirect with same-cycle request, response and pop; then back-to-back redirects.
        rst_rows(1, 1);
        row(0, 1, 0, 0,              1, 1, 1, B,              0, 0);
        row(0, 1, 0, 0,              1, 1, 1, B + 64'h4,      0, 0);
        row(0, 1, 1, 64'h9000_0000,  1, 1, 1, B + 64'h8,      1, B);
        row(0, 1, 0, 0,              1, 1, 1, 64'h9000_0000,  0, 0);
        row(0, 1, 0, 0,              1, 1, 1, 64'h9000_0004,  0, 0);
        row(0, 1, 0, 0,              1, 1, 1, 64'h9000_0008,  1, 64'h9000_0000);
        row(0, 1, 0, 0,              1, 1, 1, 64'h9000_000C,  1, 64'h9000_0004);
        row(0, 1, 1, 64'hA000_0000,  1, 1, 1, 64'h9000_0010,  1, 64'h9000_0008);
        row(0, 1, 1, 64'hB000_0006,  1, 1, 1, 64'hA000_0000,  0, 0);
        row(0, 1, 0, 0,              1, 1, 1, 64'hB000_0004,  0, 0);
        row(0, 1, 0, 0,              1, 1, 1, 64'hB000_0008,  0, 0);
        row(0, 1, 0, 0,              1, 1, 1, 64'hB000_000C,  1, 64'hB000_0004);
        row(0, 1, 0, 0,              1, 1, 1, 64'hB000_0010,  1, 64'hB000_0008);

        // Reset mid-stream with three entries queued, then restart after BOOT.
        rst_rows(0, 1);
        row(0, 0, 0, 0, 1, 1, 1, B,         0, 0);
        row(0, 0, 0, 0, 1, 1, 1, B + 64'h4, 0, 0);
        row(0, 0, 0, 0, 1, 1, 1, B + 64'h8, 1, B);
        row(0, 0, 0, 0, 1, 1, 1, B + 64'hC, 1, B);
        row(1, 0, 0, 0, 1, 0, 0, 0,         0, 0);
        row(0, 1, 0, 0, 1, 1, 0, B,         0, 0);
        row(0, 1, 0, 0, 1, 1, 1, B,         0, 0);
        row(0, 1, 0, 0, 1, 1, 1, B + 64'h4, 0, 0);
        row(0, 1, 0, 0, 1, 1, 1, B + 64'h8, 1, B);

        imem_req_ready = 1'b1;
        for (int i = 0; i < vt.size(); i++) begin
            rst            = vt[i].rst;
            out_ready      = vt[i].ordy;
            redirect_valid = vt[i].redir;
            redirect_pc    = vt[i].rpc;
            cur_lat        = vt[i].lat;
            drive_mem();
            #1;
            chk($sformatf("row%0d req_valid", i), 64'(imem_req_valid), 64'(vt[i].erv));
            if (vt[i].ca) chk($sformatf("row%0d req_addr", i), imem_req_addr, vt[i].eaddr);
            chk($sformatf("row%0d out_valid", i), 64'(out_valid), 64'(vt[i].eov));
            if (vt[i].eov) begin
                chk($sformatf("row%0d out_pc", i), out_pc, vt[i].epc);
                chk($sformatf("row%0d out_inst", i), 64'(out_inst), 64'(f_inst(vt[i].epc)));
            end
            advance();
        end

        // Randomized stalls, latencies and redirects.
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b1;
        imem_req_ready = 1'b1; cur_lat = 1;
        for (int i = 0; i < 2; i++) begin
            drive_mem(); #1; advance();
        end
        rst = 1'b0;
        drive_mem(); #1; advance();
        exp_pc = B;
        n_pop  = 0;
        for (int c = 0; c < 3000; c++) begin
            imem_req_ready = ($urandom_range(0, 3) != 0);
            out_ready      = ($urandom_range(0, 2) != 0);
            redirect_valid = ($urandom_range(0, 49) == 0);
            redirect_pc    = {$urandom, $urandom};
            cur_lat        = $urandom_range(1, 5);
            drive_mem();
            #1;
            if (out_valid && out_ready && !redirect_valid) begin
                chk($sformatf("rand cyc%0d out_pc", c), out_pc, exp_pc);
                chk($sformatf("rand cyc%0d out_inst", c), 64'(out_inst), 64'(f_inst(exp_pc)));
                exp_pc = exp_pc + 64'h4;
                n_pop++;
            end
            if (redirect_valid) exp_pc = redirect_pc & ~64'h3;
            advance();
        end
        chk("rand progress", 64'(n_pop > 200), 64'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
